// File: rtl/x_disp.sv
// ---------------------------------------------------------------------------
// x_disp -- 4-digit multiplexed 7-segment display driver for an 11-bit signed
// value.
//
// The value is captured on sel and shown as a sign and a 4-digit decimal
// magnitude. One digit is driven at a time, each for 2**REFRESH_W cycles, in
// the order rightmost .. leftmost. Values from -1024 to -1000 do not fit
// ('-' plus three digits), so they show '-' on all four digits.
//
// Optional feature (macro DISP_BLANK_EN):
//   defined   : leading zeros are blanked and a '-' sits immediately left of
//               the most significant nonzero digit.
//   undefined : all four digits show decimal digits with leading zeros, and
//               a negative value puts its '-' on the leftmost digit.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous reset, active low
//   sel      in   write strobe; data_in is captured while high
//   data_in  in   [10:0] two's-complement value to display
//   data_out out  [11:8] anodes (active low, bit 8 = rightmost digit)
//                 [7:0]  segments (active low) {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module x_disp #(
  parameter int REFRESH_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [10:0] data_in,
  output logic [11:0] data_out
);

  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  logic [10:0]          value_q;
  logic [REFRESH_W-1:0] cnt_q;
  logic [1:0]           idx_q;
  logic [11:0]          out_q;
  logic [11:0]          out_d;

  logic                 neg;
  logic                 ovf;
  logic [10:0]          mag;
  logic [10:0]          q10, q100, q1000;
  logic [3:0]           bcd [4];
  logic [1:0]           msd;
  logic [7:0]           seg_d;
  logic [3:0]           anode_d;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Sign/magnitude. -1024 negates to 11'h400, which reads correctly as an
  // unsigned 1024.
  assign neg = value_q[10];
  assign mag = neg ? (~value_q + 11'd1) : value_q;
  assign ovf = neg && (mag >= 11'd1000);

  // Binary to BCD by constant division; mag <= 1024 so every digit fits.
  assign q10    = mag / 11'd10;
  assign q100   = mag / 11'd100;
  assign q1000  = mag / 11'd1000;
  assign bcd[0] = 4'(mag   % 11'd10);
  assign bcd[1] = 4'(q10   % 11'd10);
  assign bcd[2] = 4'(q100  % 11'd10);
  assign bcd[3] = 4'(q1000 % 11'd10);

  // Position of the most significant nonzero digit (0 when the value is 0).
  always_comb begin
    msd = 2'd0;
    if (bcd[3] != 4'd0)      msd = 2'd3;
    else if (bcd[2] != 4'd0) msd = 2'd2;
    else if (bcd[1] != 4'd0) msd = 2'd1;
  end

  always_comb begin
    seg_d = seg7(bcd[idx_q]);
    if (ovf) begin
      seg_d = SEG_DASH;
    end else begin
`ifdef DISP_BLANK_EN
      // A negative in-range value has msd <= 2, so msd+1 is always a digit.
      if (idx_q > msd) begin
        seg_d = (neg && (idx_q == 2'(msd + 2'd1))) ? SEG_DASH : SEG_BLANK;
      end
`else
      if (neg && (idx_q == 2'd3)) begin
        seg_d = SEG_DASH;
      end
`endif
    end
  end

  assign anode_d = ~(4'b0001 << idx_q);
  assign out_d   = {anode_d, seg_d};

  // The digit index advances only when the refresh counter wraps, so the
  // scan is independent of capture activity.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_q <= '0;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      out_q   <= 12'hFFF;
    end else begin
      if (sel) begin
        value_q <= data_in;
      end
      cnt_q <= cnt_q + REFRESH_W'(1);
      if (cnt_q == {REFRESH_W{1'b1}}) begin
        idx_q <= idx_q + 2'd1;
      end
      out_q <= out_d;
    end
  end

  assign data_out = out_q;

endmodule

// File: tb/tb_x_disp.sv
// ---------------------------------------------------------------------------
// tb_x_disp -- directed bench for x_disp with REFRESH_W = 2 (each digit is
// driven for 4 cycles, full scan every 16 cycles). Expected segment patterns
// are hand-written for both builds of DISP_BLANK_EN.
// ---------------------------------------------------------------------------
module tb_x_disp;

  localparam int REFRESH_W = 2;

`ifdef DISP_BLANK_EN
  localparam logic [7:0] LZ = 8'hFF;   // leading position: blank
`else
  localparam logic [7:0] LZ = 8'hC0;   // leading position: zero
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic [10:0] data_in = '0;
  logic [11:0] data_out;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] dig [4];

  x_disp #(.REFRESH_W(REFRESH_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .sel      (sel),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Release reset mid-cycle and check the scan from the first edge: digit 0
  // first, 4 cycles per anode, order 8,9,10,11 and wrap back to 8, showing 0.
  task automatic reset_scan_check(input string tag);
    logic [3:0] an;
    logic [7:0] sg;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      an = ~(4'b0001 << (((k - 1) / 4) % 4));
      sg = (((k - 1) / 4) % 4 == 0) ? 8'hC0 : LZ;
      check($sformatf("%s_cyc%0d", tag, k), data_out, {an, sg});
    end
  endtask

  // Sample one full scan and sort segment values by the active anode.
  task automatic read_scan(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 4; i++) dig[i] = 8'hxx;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      case (data_out[11:8])
        4'b1110: dig[0] = data_out[7:0];
        4'b1101: dig[1] = data_out[7:0];
        4'b1011: dig[2] = data_out[7:0];
        4'b0111: dig[3] = data_out[7:0];
        default: bad++;
      endcase
    end
    check({tag, "_onehot"}, 12'(bad), 12'd0);
  endtask

  task automatic check_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                              input logic [7:0] e1, input logic [7:0] e0);
    read_scan(tag);
    check({tag, "_d3"}, {4'h0, dig[3]}, {4'h0, e3});
    check({tag, "_d2"}, {4'h0, dig[2]}, {4'h0, e2});
    check({tag, "_d1"}, {4'h0, dig[1]}, {4'h0, e1});
    check({tag, "_d0"}, {4'h0, dig[0]}, {4'h0, e0});
  endtask

  task automatic capture(input logic [10:0] v);
    @(negedge clk);
    data_in = v;
    sel     = 1'b1;
    @(negedge clk);
    sel     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    // Reset held from time 0
    repeat (3) @(negedge clk);
    check("reset_hold", data_out, 12'hFFF);
    reset_scan_check("rst_release");

    capture(11'd123);
    check_digits("v123", LZ, 8'hF9, 8'hA4, 8'hB0);

    capture(11'h7D3);  // -45
`ifdef DISP_BLANK_EN
    check_digits("vm45", 8'hFF, 8'hBF, 8'h99, 8'h92);
`else
    check_digits("vm45", 8'hBF, 8'hC0, 8'h99, 8'h92);
`endif

    capture(11'h400);  // -1024
    check_digits("vm1024", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    capture(11'h418);  // -1000
    check_digits("vm1000", 8'hBF, 8'hBF, 8'hBF, 8'hBF);

    capture(11'h419);  // -999
    check_digits("vm999", 8'hBF, 8'h90, 8'h90, 8'h90);

    capture(11'd1023);
    check_digits("v1023", 8'hF9, 8'hC0, 8'hA4, 8'hB0);

    // Data changes with sel low must not reach the display
    @(negedge clk);
    data_in = 11'd5;
    repeat (4) @(negedge clk);
    data_in = 11'h7F9;
    check_digits("sel_low", 8'hF9, 8'hC0, 8'hA4, 8'hB0);

    capture(11'd7);
    check_digits("v7", LZ, LZ, LZ, 8'hF8);

    capture(11'h7F9);  // -7
`ifdef DISP_BLANK_EN
    check_digits("vm7", 8'hFF, 8'hFF, 8'hBF, 8'hF8);
`else
    check_digits("vm7", 8'hBF, 8'hC0, 8'hC0, 8'hF8);
`endif

    // sel held high: last captured value wins
    @(negedge clk);
    sel = 1'b1;
    data_in = 11'd500;
    @(negedge clk);
    data_in = 11'h6D4;  // -300
    @(negedge clk);
    data_in = 11'd321;
    @(negedge clk);
    sel = 1'b0;
    repeat (3) @(negedge clk);
    check_digits("sustain", LZ, 8'hB0, 8'hA4, 8'hF9);

    capture(11'd0);
    check_digits("v0", LZ, LZ, LZ, 8'hC0);

    // Asynchronous reset pulse mid-scan
    capture(11'd1023);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check("async_rst", data_out, 12'hFFF);
    reset_scan_check("rst_mid");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/x_disp.md
X_DISP -- requirements
Module: x_disp

Interface
REQ-001 SHALL have parameter REFRESH_W, default 16, meaning log2 of clk cycles each digit is driven (legal 1..24).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state on rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-low.
REQ-004 SHALL have port sel, input, 1, write strobe from the address decoder; data_in captured when high.
REQ-005 SHALL have port data_in, input, 11, value to display, two's complement (-1024..1023).
REQ-006 SHALL have port data_out, output, 12; [11:8] digit anodes, active-low, bit 8 = rightmost digit; [7:0] segments, active-low, {dp,g,f,e,d,c,b,a}.

Function
REQ-007 SHALL capture data_in into an internal 11-bit value register on each rising clk edge with sel high; hold it otherwise; sel sustained high re-captures every cycle.
REQ-008 SHALL convert the captured value to sign plus 4-digit BCD magnitude (combinational or sequential); data_out SHALL reflect a new value no later than 16 clk cycles after the capturing edge.
REQ-009 SHALL, for 0..1023, show the magnitude on the 4 digits (thousands digit leftmost).
REQ-010 SHALL, for -999..-1, show '-' on the digit immediately left of the most significant nonzero digit (leftmost digit when leading blanking is disabled) and the magnitude on the digits to its right.
REQ-011 SHALL, for -1024..-1000 (not representable), show '-' on all four digits.
REQ-012 SHALL use segment codes (hex, active-low): 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 '-'=BF blank=FF; dp always off (bit 7 = 1).
REQ-013 SHALL time-multiplex: a REFRESH_W-bit free-running counter; a 2-bit digit index increments (wrapping 3->0) when the counter wraps; exactly one anode low at any time, the one selected by the index.
REQ-014 SHALL register data_out (no combinational path from data_in or sel to data_out).
REQ-015 SHALL keep scanning unaffected by sel/data_in; a capture mid-scan only changes segment content.

Reset
REQ-016 SHALL, while rst is low, force data_out = FFF (all anodes and segments off), value register = 0, refresh counter = 0, digit index = 0.
REQ-017 SHALL, after rst deassertion, start scanning at digit 0 (rightmost) and display value 0.
REQ-018 SHALL abort any in-progress conversion on reset assertion at any cycle, with no stale value shown afterwards.

Configuration
REQ-019 SHALL support macro DISP_BLANK_EN: when defined, leading zeros of the magnitude are blanked (FF), value 0 showing only '0' on digit 0; when undefined, all four digits show decimal digits with leading zeros and a negative value's '-' occupies the leftmost digit.

Verification
REQ-020 Reset: rst low -> data_out = FFF; after release, with DISP_BLANK_EN, digit 0 shows C0 and digits 1-3 show FF.
REQ-021 Capture 123 (sel one cycle), REFRESH_W=2 -> within 16 cycles, scan shows digit0=B0, digit1=A4, digit2=F9, digit3=FF; each anode low for 4 cycles, order 8,9,10,11, then wrap to 8.
REQ-022 Capture -45 (11'h7D3), DISP_BLANK_EN -> digit0=92, digit1=99, digit2=BF, digit3=FF.
REQ-023 Capture -1024 (11'h400) -> all four digits BF; capture 1023 -> digits 3..0 = F9,C0,A4,B0.
REQ-024 data_in changes with sel low -> display unchanged; rst pulsed low mid-scan -> data_out FFF immediately (asynchronous), restart at digit 0 showing 0.
REQ-025 DISP_BLANK_EN undefined, capture 7 -> digits 3..0 = C0,C0,C0,F8; capture -7 -> BF,C0,C0,F8.
